nand_page_buf_ctrl: RTL and testbench

//  Sequences the 1024x32 two-port page SRAM (sync write, 1-cycle registered read) as a NAND page buffer.

---
 rtl/nand_bridge_pkg.sv | 15 +
 rtl/page_rd_skid.sv | 47 ++++
 rtl/nand_page_buf_ctrl.sv | 160 ++++++++++++++++
 tb/tb_nand_page_buf_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_bridge_pkg.sv
// Shared types and default geometry for the NAND page buffer in the host-to-NAND bridge.
package nand_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL,
    DRAIN
  } buf_state_t;

  localparam int PAGE_WORDS_DEF = 528;
  localparam int SRAM_AW        = 10;
  localparam int SRAM_DW        = 32;

endpackage

// File: rtl/page_rd_skid.sv
// Two-entry FIFO that absorbs registered SRAM read data so the NAND side sees
// one word per clock under backpressure; count feeds the read-issue throttle.
module page_rd_skid #(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the two data slots are reset because the head drives rd_data directly, which must be 0 out of reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/nand_page_buf_ctrl.sv
// NAND page buffer sequencer: fills the page SRAM from the host stream, then
// drains it to the NAND data-phase engine with read latency hidden by a skid.
module nand_page_buf_ctrl
  import nand_bridge_pkg::*;
#(
  parameter int PAGE_WORDS = PAGE_WORDS_DEF,
  parameter int AW         = SRAM_AW,
  parameter int DW         = SRAM_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          fill_commit,
  input  logic          drain_start,
  input  logic          abort,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  input  logic          rd_ready,
  output logic          page_full,
  output logic [AW-1:0] page_len,
  output logic          drain_done,
  output logic [AW-1:0] sram_waddr,
  output logic [DW-1:0] sram_wd,
  output logic          sram_wen,
  output logic [AW-1:0] sram_raddr,
  input  logic [DW-1:0] sram_rd
);

  localparam logic [AW-1:0] FULL_LEN = AW'(PAGE_WORDS);

  buf_state_t    state;
  buf_state_t    state_nxt;
  logic [AW-1:0] wcnt;
  logic [AW-1:0] rcnt;
  logic [AW-1:0] taken;
  logic [AW-1:0] wcnt_inc;
  logic          in_fill;
  logic          wr_fire;
  logic          rd_fire;
  logic          fill_done;
  logic          drain_go;
  logic          drain_end;
  logic          issue;
  logic          rd_pend;
  logic          is_last;
  logic [1:0]    skid_count;
  logic [1:0]    occ_after;
  logic [DW-1:0] skid_head;

  assign in_fill   = (state == IDLE) || (state == FILL);
  assign wr_fire   = wr_valid & wr_ready;
  assign wcnt_inc  = wcnt + AW'(wr_fire);
  // A commit coinciding with an accepted word closes the page including that word.
  assign fill_done = in_fill && !abort &&
                     ((wr_fire && (wcnt_inc == FULL_LEN)) || (fill_commit && (wcnt_inc != '0)));
  assign drain_go  = (state == FULL) && drain_start && !abort;

  assign rd_valid  = (skid_count != 2'd0);
  assign rd_fire   = rd_valid & rd_ready & !abort;
  assign is_last   = (taken == page_len - AW'(1));
  assign rd_last   = rd_valid & is_last;
  assign drain_end = (state == DRAIN) && rd_fire && is_last;

  // Reads in flight plus skid entries, net of this cycle's pop, must stay below two.
  assign occ_after = skid_count + {1'b0, rd_pend} - {1'b0, rd_fire};
  assign issue     = ((state == DRAIN) || drain_go) && !abort &&
                     (rcnt < page_len) && (occ_after < 2'd2);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred on untaken paths.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, FILL: begin
          if (fill_done)    state_nxt = FULL;
          else if (wr_fire) state_nxt = FILL;
        end
        FULL:    if (drain_start) state_nxt = DRAIN;
        DRAIN:   if (drain_end)   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ready  = 1'b0;
    page_full = 1'b0;
    case (state)
      IDLE, FILL:  wr_ready  = !abort;
      FULL, DRAIN: page_full = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wcnt       <= '0;
      rcnt       <= '0;
      taken      <= '0;
      page_len   <= '0;
      rd_pend    <= 1'b0;
      drain_done <= 1'b0;
    end else if (abort) begin
      wcnt       <= '0;
      rcnt       <= '0;
      taken      <= '0;
      page_len   <= '0;
      rd_pend    <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      drain_done <= drain_end;
      rd_pend    <= issue;
      if (wr_fire)   wcnt     <= wcnt_inc;
      if (fill_done) page_len <= wcnt_inc;
      if (issue)     rcnt     <= rcnt + AW'(1);
      if (rd_fire)   taken    <= taken + AW'(1);
      if (drain_end) begin
        wcnt     <= '0;
        rcnt     <= '0;
        taken    <= '0;
        page_len <= '0;
      end
    end
  end

  assign sram_wen   = wr_fire;
  assign sram_waddr = wcnt;
  assign sram_wd    = wr_fire ? wr_data : '0;
  assign sram_raddr = rcnt;

  // Data for a read issued before an abort is dropped at the skid input.
  page_rd_skid #(
    .DW(DW)
  ) u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (abort),
    .push      (rd_pend & !abort),
    .push_data (sram_rd),
    .pop       (rd_fire),
    .head_data (skid_head),
    .count     (skid_count)
  );

  assign rd_data = skid_head;

endmodule

// File: tb/tb_nand_page_buf_ctrl.sv
// Directed bench for nand_page_buf_ctrl with a behavioural 1024x32 page SRAM.
module tb_nand_page_buf_ctrl;
  import nand_bridge_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int PW = 528;

  logic          CLK = 1'b0;
  logic          RST;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          fill_commit;
  logic          drain_start;
  logic          abort;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          rd_ready;
  logic          page_full;
  logic [AW-1:0] page_len;
  logic          drain_done;
  logic [AW-1:0] sram_waddr;
  logic [DW-1:0] sram_wd;
  logic          sram_wen;
  logic [AW-1:0] sram_raddr;
  logic [DW-1:0] sram_rd;

  logic [DW-1:0] sram_mem [1024];

  int errors = 0;
  int checks = 0;

  nand_page_buf_ctrl #(
    .PAGE_WORDS(PW),
    .AW(AW),
    .DW(DW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .fill_commit (fill_commit),
    .drain_start (drain_start),
    .abort       (abort),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .rd_ready    (rd_ready),
    .page_full   (page_full),
    .page_len    (page_len),
    .drain_done  (drain_done),
    .sram_waddr  (sram_waddr),
    .sram_wd     (sram_wd),
    .sram_wen    (sram_wen),
    .sram_raddr  (sram_raddr),
    .sram_rd     (sram_rd)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (sram_wen) sram_mem[sram_waddr] <= sram_wd;
    sram_rd <= sram_mem[sram_raddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_words(input int n, input logic [31:0] base, input bit commit_last);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      wr_valid    = 1'b1;
      wr_data     = base + 32'(i);
      fill_commit = commit_last && (i == n - 1);
      #1;
      check($sformatf("wr_ready[%0d]", i), wr_ready, 1'b1);
      check($sformatf("sram_wen[%0d]", i), sram_wen, 1'b1);
      check($sformatf("sram_waddr[%0d]", i), sram_waddr, 32'(i));
      check($sformatf("sram_wd[%0d]", i), sram_wd, base + 32'(i));
      if (i == n - 1) check("page_full_before_close", page_full, 1'b0);
    end
    @(negedge CLK);
    wr_valid    = 1'b0;
    wr_data     = '0;
    fill_commit = 1'b0;
    #1;
  endtask

  task automatic drain_page(input int n, input logic [31:0] base, input bit bp, input int abort_at);
    int k;
    int cyc;
    int first_v;
    int gaps;
    int max_cnt;
    int early_done;
    k = 0; cyc = 0; first_v = -1; gaps = 0; max_cnt = 0; early_done = 0;
    @(negedge CLK);
    drain_start = 1'b1;
    rd_ready    = 1'b1;
    #1;
    check("rd_valid_at_drain_start", rd_valid, 1'b0);
    while (k < n && k != abort_at && cyc < 4000) begin
      @(negedge CLK);
      drain_start = 1'b0;
      rd_ready    = bp ? ($urandom_range(0, 99) >= 30) : 1'b1;
      #1;
      cyc++;
      if (rd_valid && first_v < 0) first_v = cyc;
      if (int'(dut.u_skid.count) > max_cnt) max_cnt = int'(dut.u_skid.count);
      if (!rd_valid && k > 0) gaps++;
      if (drain_done) early_done++;
      if (rd_valid && rd_ready) begin
        check($sformatf("rd_data[%0d]", k), rd_data, base + 32'(k));
        check($sformatf("rd_last[%0d]", k), rd_last, (k == n - 1));
        k++;
      end
    end
    check("first_rd_valid_latency", 32'(first_v), 32'd2);
    check("skid_count_max_le2", (max_cnt <= 2), 1'b1);
    check("drain_done_early", 32'(early_done), 32'd0);
    if (!bp) check("burst_gaps", 32'(gaps), 32'd0);
    if (abort_at >= 0) begin
      check("words_before_abort", 32'(k), 32'(abort_at));
      return;
    end
    check("words_taken", 32'(k), 32'(n));
    @(negedge CLK);
    rd_ready = 1'b0;
    #1;
    check("drain_done_pulse", drain_done, 1'b1);
    check("rd_valid_after_drain", rd_valid, 1'b0);
    check("page_full_after_drain", page_full, 1'b0);
    check("page_len_after_drain", 32'(page_len), 32'd0);
    check("wr_ready_after_drain", wr_ready, 1'b1);
    check("state_after_drain", 32'(dut.state), 32'(IDLE));
    @(negedge CLK);
    #1;
    check("drain_done_single", drain_done, 1'b0);
  endtask

  initial begin
    RST = 1'b1;
    wr_valid = 1'b0; wr_data = '0; fill_commit = 1'b0;
    drain_start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    #3;
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_rd_last", rd_last, 1'b0);
    check("rst_page_full", page_full, 1'b0);
    check("rst_page_len", 32'(page_len), 32'd0);
    check("rst_drain_done", drain_done, 1'b0);
    check("rst_sram_wen", sram_wen, 1'b0);
    check("rst_sram_waddr", 32'(sram_waddr), 32'd0);
    check("rst_sram_raddr", 32'(sram_raddr), 32'd0);
    check("rst_sram_wd", sram_wd, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // fill_commit with nothing written stays in IDLE
    @(negedge CLK);
    fill_commit = 1'b1;
    #1;
    @(negedge CLK);
    fill_commit = 1'b0;
    #1;
    check("idle_commit_state", 32'(dut.state), 32'(IDLE));
    check("idle_commit_page_full", page_full, 1'b0);
    check("idle_commit_page_len", 32'(page_len), 32'd0);
    check("idle_commit_waddr", 32'(sram_waddr), 32'd0);

    // full page, no backpressure
    fill_words(PW, 32'd0, 1'b0);
    check("full_page_full", page_full, 1'b1);
    check("full_page_len", 32'(page_len), 32'(PW));
    check("full_wr_ready", wr_ready, 1'b0);
    check("full_state", 32'(dut.state), 32'(FULL));
    drain_page(PW, 32'd0, 1'b0, -1);

    // short page plus ignored events
    fill_words(5, 32'hA000_0000, 1'b0);
    @(negedge CLK);
    drain_start = 1'b1;
    #1;
    @(negedge CLK);
    drain_start = 1'b0;
    #1;
    check("fill_drain_state", 32'(dut.state), 32'(FILL));
    check("fill_drain_page_full", page_full, 1'b0);
    check("fill_drain_waddr", 32'(sram_waddr), 32'd5);
    @(negedge CLK);
    #1;
    check("fill_drain_rd_valid", rd_valid, 1'b0);
    @(negedge CLK);
    fill_commit = 1'b1;
    #1;
    @(negedge CLK);
    fill_commit = 1'b0;
    #1;
    check("short_page_full", page_full, 1'b1);
    check("short_page_len", 32'(page_len), 32'd5);
    @(negedge CLK);
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD_BEEF;
    #1;
    check("full_wr_ready_low", wr_ready, 1'b0);
    check("full_no_sram_wen", sram_wen, 1'b0);
    @(negedge CLK);
    wr_valid = 1'b0;
    wr_data  = '0;
    #1;
    check("full_wr_page_len", 32'(page_len), 32'd5);
    check("full_wr_waddr", 32'(sram_waddr), 32'd5);
    check("full_wr_state", 32'(dut.state), 32'(FULL));
    drain_page(5, 32'hA000_0000, 1'b0, -1);

    // full page under random backpressure
    fill_words(PW, 32'h5000_0000, 1'b0);
    drain_page(PW, 32'h5000_0000, 1'b1, -1);

    // abort mid-drain, then a 3-word page committed on its last word
    fill_words(PW, 32'h0001_0000, 1'b0);
    drain_page(PW, 32'h0001_0000, 1'b0, 100);
    @(negedge CLK);
    abort    = 1'b1;
    rd_ready = 1'b1;
    #1;
    @(negedge CLK);
    abort = 1'b0;
    #1;
    check("abort_state", 32'(dut.state), 32'(IDLE));
    check("abort_rd_valid", rd_valid, 1'b0);
    check("abort_wr_ready", wr_ready, 1'b1);
    check("abort_page_full", page_full, 1'b0);
    check("abort_page_len", 32'(page_len), 32'd0);
    check("abort_sram_wen", sram_wen, 1'b0);
    check("abort_raddr", 32'(sram_raddr), 32'd0);
    @(negedge CLK);
    #1;
    check("abort_inflight_dropped", rd_valid, 1'b0);
    rd_ready = 1'b0;
    fill_words(3, 32'hC0DE_0000, 1'b1);
    check("commit_coincident_len", 32'(page_len), 32'd3);
    check("commit_coincident_full", page_full, 1'b1);
    drain_page(3, 32'hC0DE_0000, 1'b0, -1);

    // asynchronous reset in the middle of a fill
    fill_words(10, 32'h7700_0000, 1'b0);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("arst_state", 32'(dut.state), 32'(IDLE));
    check("arst_wr_ready", wr_ready, 1'b1);
    check("arst_page_full", page_full, 1'b0);
    check("arst_page_len", 32'(page_len), 32'd0);
    check("arst_waddr", 32'(sram_waddr), 32'd0);
    check("arst_sram_wen", sram_wen, 1'b0);
    check("arst_rd_valid", rd_valid, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    fill_words(4, 32'h8800_0000, 1'b1);
    check("refill_page_len", 32'(page_len), 32'd4);
    drain_page(4, 32'h8800_0000, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
